// File: rtl/fc_layer_sequencer_pkg.sv
// Shared types and sizing helpers for the fully-connected layer sequencer.
package fc_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_OUT
    } state_t;

    localparam int SETTLE_CNT_W = 4;

    // Layer output width: product of two WIDTH-bit values plus adder-tree growth.
    function automatic int calc_out_w(input int width, input int n_in);
        return width * 2 + $clog2(n_in);
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Activation input stream and result output stream of the sequencer.
interface fc_layer_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 23
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fc_layer_sequencer_input_bank.sv
// IN x WIDTH activation register bank feeding the layer's x[] inputs.
module fc_input_bank #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(IN)-1:0]    wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     clr,
    output logic [WIDTH*IN-1:0]      x_bus
);
    logic [IN-1:0][WIDTH-1:0] bank;

    // Clear wins over write so a cleared bank always starts the next vector at zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[wr_idx] <= wr_data;
        end
    end

    assign x_bus = bank;
endmodule

// File: rtl/fc_layer_sequencer.sv
// Loads a vector of activations, holds it for the layer to settle, then
// registers the layer result onto a valid/ready output stream.
//
// state     | meaning
// ST_LOAD   | accepting activation beats into the bank
// ST_SETTLE | bank frozen, counting down the settle time
// ST_OUT    | result held on out_data until downstream accepts
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int IN            = 128,
    parameter int OUT_W         = calc_out_w(WIDTH, IN),
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fc_layer_sequencer_if.slave       s,
    output logic [WIDTH*IN-1:0]       x_bus,
    input  logic [OUT_W-1:0]          z_in,
    output logic                      busy,
    output logic                      err_len
);
    localparam int IDX_W = $clog2(IN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [SETTLE_CNT_W-1:0] cnt;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q;

    logic accept;
    logic last_beat;
    logic out_fire;

    assign accept    = s.in_valid && in_ready_q;
    assign last_beat = (idx == IDX_LAST) || s.in_last;
    assign out_fire  = out_valid_q && s.out_ready;

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign busy        = (state != ST_LOAD) || (idx != '0);

    fc_input_bank #(
        .WIDTH (WIDTH),
        .IN    (IN)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_idx  (idx),
        .wr_data (s.in_data),
        .clr     (out_fire),
        .x_bus   (x_bus)
    );

    // Sequencer FSM with registered handshake outputs, settle timer and length check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            idx         <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_len     <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (last_beat) begin
                            state      <= ST_SETTLE;
                            cnt        <= SETTLE_CNT_W'(SETTLE_CYCLES - 1);
                            idx        <= '0;
                            in_ready_q <= 1'b0;
                            // Short vector (early last) or overlong one (no last at the end).
                            if (s.in_last != (idx == IDX_LAST)) begin
                                err_len <= 1'b1;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        out_data_q  <= z_in;
                        out_valid_q <= 1'b1;
                        state       <= ST_OUT;
                    end else begin
                        cnt <= cnt - SETTLE_CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule
